// File: rtl/reg_bank_pkg.sv
// Shared types for the debounced register bank: debounce FSM states and address-width helper.
package reg_bank_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_e;

    function automatic int addr_w(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debounce FSM; emits one wr_pulse per debounced press.
// Pulse appears DEBOUNCE_CYCLES+2 cycles after btn_wr rises; no backpressure, release must also be stable.
module btn_debounce
    import reg_bank_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_wr,
    output logic wr_pulse,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          btn_s_q;
    db_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = HELD;
                    wr_pulse = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s_q) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_wr;
            btn_s_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: rtl/reg_bank_debounced.sv
// Demux-written register bank strobed by a debounced button, with registered read, valid flags and write counter.
// Read latency 1 cycle (read-before-write); write lands DEBOUNCE_CYCLES+3 edges after press; no backpressure.
module reg_bank_debounced
    import reg_bank_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 8,
    localparam int ADDR_W         = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_wr,
    input  logic              clr,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic [DEPTH-1:0]  valid_map,
    output logic [CNT_W-1:0]  wr_count,
    output logic              busy
);

    logic             wr_pulse;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_wr   (btn_wr),
        .wr_pulse (wr_pulse),
        .busy     (busy)
    );

    always_comb begin
        mem_d      = mem_q;
        valid_d    = valid_q;
        count_d    = count_q;
        rd_data_d  = '0;
        rd_valid_d = 1'b0;
        // clr wins over a coincident write; that write is simply lost
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            valid_d = '0;
        end else if (wr_pulse && (int'(wr_addr) < DEPTH)) begin
            mem_d[wr_addr]   = wr_data;
            valid_d[wr_addr] = 1'b1;
            count_d          = count_q + CNT_W'(1);
        end
        if (int'(rd_addr) < DEPTH) begin
            rd_data_d  = mem_q[rd_addr];
            rd_valid_d = valid_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            valid_q    <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign valid_map = valid_q;
    assign wr_count  = count_q;

endmodule

// File: tb/tb_reg_bank_debounced.sv
// Directed + randomized bench for reg_bank_debounced against a run-length button model and array scoreboard.
module tb_reg_bank_debounced;

    localparam int W  = 8;
    localparam int DP = 5;
    localparam int D  = 4;
    localparam int CW = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          btn_wr = 1'b0;
    logic          clr = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [W-1:0]  rd_data;
    logic          rd_valid;
    logic [DP-1:0] valid_map;
    logic [CW-1:0] wr_count;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;

    // reference model: button level is "pressed" once D+1 consecutive synchronised samples disagree with it
    logic [W-1:0]  m_mem [DP];
    logic [DP-1:0] m_vmap;
    int            m_count;
    logic          m_level;
    int            m_run;
    logic          m_s1, m_s2;
    logic [W-1:0]  e_rd_data;
    logic          e_rd_valid;

    reg_bank_debounced #(
        .WIDTH(W), .DEPTH(DP), .DEBOUNCE_CYCLES(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_wr(btn_wr), .clr(clr),
        .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .valid_map(valid_map),
        .wr_count(wr_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
        m_vmap = '0; m_count = 0; m_level = 1'b0; m_run = 0;
        m_s1 = 1'b0; m_s2 = 1'b0; e_rd_data = '0; e_rd_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic pulse;
        if (!rst_n) begin
            model_reset();
            return;
        end
        pulse = 1'b0;
        if (m_s2 != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = m_s2;
                m_run   = 0;
                pulse   = m_s2;
            end
        end else begin
            m_run = 0;
        end
        if (int'(rd_addr) < DP) begin
            e_rd_data  = m_mem[rd_addr];
            e_rd_valid = m_vmap[rd_addr];
        end else begin
            e_rd_data  = '0;
            e_rd_valid = 1'b0;
        end
        if (clr) begin
            for (int i = 0; i < DP; i++) m_mem[i] = '0;
            m_vmap = '0;
        end else if (pulse && int'(wr_addr) < DP) begin
            m_mem[wr_addr]  = wr_data;
            m_vmap[wr_addr] = 1'b1;
            m_count         = (m_count + 1) % 256;
        end
        m_s2 = m_s1;
        m_s1 = btn_wr;
    endtask

    task automatic compare_all();
        chk("rd_data", rd_data, e_rd_data);
        chk("rd_valid", rd_valid, e_rd_valid);
        chk("valid_map", valid_map, m_vmap);
        chk("wr_count", wr_count, m_count);
        chk("busy", busy, (m_level || m_run != 0));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic press(input int hi, input int lo);
        btn_wr = 1'b1;
        repeat (hi) step();
        btn_wr = 1'b0;
        repeat (lo) step();
    endtask

    initial begin
        logic [7:0]    c0;
        logic [DP-1:0] vm0;
        model_reset();

        // 1: reset and idle
        rd_addr = 3'd2;
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();
        chk("t1_rd_data", rd_data, 0);
        chk("t1_rd_valid", rd_valid, 0);
        chk("t1_count", wr_count, 0);
        chk("t1_busy", busy, 0);

        // 2: clean press, write lands on edge D+3 = 7
        wr_addr = 3'd1; wr_data = 8'hA5; rd_addr = 3'd1;
        btn_wr = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (e == 6) chk("t2_before_edge7", wr_count, 0);
            if (e == 7) begin
                chk("t2_vmap", valid_map, 5'b00010);
                chk("t2_count", wr_count, 1);
                chk("t2_rd_old", rd_valid, 0);
            end
            if (e == 8) begin
                chk("t2_rd_data", rd_data, 8'hA5);
                chk("t2_rd_valid", rd_valid, 1);
            end
        end
        chk("t2_single_write", wr_count, 1);
        btn_wr = 1'b0;
        repeat (10) step();

        // 3: bounce rejection
        repeat (3) begin
            btn_wr = 1'b1; step(); step();
            btn_wr = 1'b0; step();
        end
        repeat (8) step();
        chk("t3_busy_idle", busy, 0);
        chk("t3_no_write", wr_count, 1);
        press(12, 10);
        chk("t3_clean_after", wr_count, 2);

        // 4: clr in the wr_pulse cycle
        wr_addr = 3'd3; wr_data = 8'h3C;
        btn_wr = 1'b1;
        repeat (6) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_vmap", valid_map, 0);
        chk("t4_count", wr_count, 2);
        rd_addr = 3'd3;
        step();
        chk("t4_mem3", rd_data, 0);
        btn_wr = 1'b0;
        repeat (10) step();

        // 5a: same-address write/read
        wr_addr = 3'd2; wr_data = 8'h11; rd_addr = 3'd2;
        press(12, 10);
        wr_data = 8'h5A;
        btn_wr = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) chk("t5_rbw_old", rd_data, 8'h11);
            if (e == 8) chk("t5_rbw_new", rd_data, 8'h5A);
        end
        btn_wr = 1'b0;
        repeat (10) step();

        // 5b: 256 presses wrap the counter
        c0 = m_count[7:0];
        for (int p = 0; p < 256; p++) begin
            wr_addr = AW'($urandom_range(0, DP - 1));
            wr_data = W'($urandom);
            rd_addr = AW'($urandom_range(0, 7));
            press(D + 6, D + 6);
        end
        chk("t5_wrap", wr_count, c0);

        // 5c: out-of-range write ignored
        c0 = m_count[7:0]; vm0 = m_vmap;
        wr_addr = 3'd5; wr_data = 8'hEE;
        press(12, 10);
        chk("t5_oor_count", wr_count, c0);
        chk("t5_oor_vmap", valid_map, vm0);

        // 6: async reset mid PRESS_WAIT
        wr_addr = 3'd4; wr_data = 8'h77;
        btn_wr = 1'b1;
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t6_busy_async", busy, 0);
        chk("t6_count_async", wr_count, 0);
        step();
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6) chk("t6_no_early", wr_count, 0);
            if (e == 7) chk("t6_fresh_write", valid_map, 5'b10000);
        end
        btn_wr = 1'b0;
        repeat (10) step();

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 7) == 0) btn_wr = ~btn_wr;
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = W'($urandom);
            rd_addr = AW'($urandom_range(0, 7));
            clr     = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
